vga_band_fetch: RTL

Parametrised pixel fetcher between the VGA timing generator and the dual-port video RAM. It maps screen coordinates onto two ping-pong band buffers and issues one RAM read per active pixel. It also extracts the 8-bit pixel lane from a DATA_W-bit word, with configurable RAM read latency. A per-buffer valid handshake with the band producer lets bands be refilled while the other buffer is displayed, and detects display underflow.

---
 rtl/vga_band_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_band_fetch.sv
// vga_band_fetch: maps VGA coordinates onto two ping-pong band buffers,
// issues one RAM word read per active pixel and extracts the pixel lane
// after RD_LAT edges. Tracks per-buffer fill state and display underflow.
module vga_band_fetch #(
   parameter int unsigned       H_ACTIVE   = 640,
   parameter int unsigned       V_ACTIVE   = 480,
   parameter int unsigned       BAND_LINES = 16,
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] BUF1_START = 16'h0000,
   parameter logic [ADDR_W-1:0] BUF2_START = 16'h2800,
   parameter int unsigned       RD_LAT     = 1,
   parameter logic [7:0]        BLANK_PIX  = 8'h00
) (
   input  logic              CLK33MHz,
   input  logic              RST,
   input  logic [10:0]       XCoord,
   input  logic [10:0]       YCoord,
   input  logic [DATA_W-1:0] DATA_OUT_VGA,
   output logic [ADDR_W-1:0] RADDR_VGA,
   output logic [7:0]        pixel_in,
   output logic              pixel_valid,
   input  logic [1:0]        fill_done,
   output logic [1:0]        buf_valid,
   output logic              band_done,
   output logic              band_buf,
   output logic              underflow,
   input  logic              clr_underflow
);

   localparam int unsigned PPW    = DATA_W / 8;
   localparam int unsigned LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int unsigned LB_W   = $clog2(BAND_LINES);

   logic                          active;
   logic                          sel;
   logic                          blank;
   logic                          last;
   logic [LB_W-1:0]               lb;
   logic [31:0]                   off;
   logic [LANE_W-1:0]             lane;
   logic [ADDR_W-1:0]             raddr_next;
   logic [1:0]                    clr_mask;
   logic [7:0]                    lane_pix;

   logic [RD_LAT-1:0]             pipe_act;
   logic [RD_LAT-1:0]             pipe_blank;
   logic [RD_LAT-1:0][LANE_W-1:0] pipe_lane;

   // Decode the current coordinate into buffer, word address and lane.
   always_comb begin
      active     = (32'(XCoord) < H_ACTIVE) && (32'(YCoord) < V_ACTIVE);
      lb         = YCoord[LB_W-1:0];
      sel        = YCoord[LB_W];
      off        = 32'(lb) * H_ACTIVE + 32'(XCoord);
      lane       = LANE_W'(off % PPW);
      raddr_next = ADDR_W'((sel ? 32'(BUF2_START) : 32'(BUF1_START)) + off / PPW);
      blank      = active && !buf_valid[sel];
      last       = active && (32'(XCoord) == H_ACTIVE - 1) && (32'(lb) == BAND_LINES - 1);
      clr_mask   = last ? (2'b01 << sel) : 2'b00;
   end

   // Select the lane carried at the tail of the pipeline; lane 0 is the MSB byte.
   always_comb begin
      lane_pix = DATA_OUT_VGA[7:0];
      for (int unsigned i = 0; i < PPW; i++) begin
         if (pipe_lane[RD_LAT-1] == LANE_W'(i))
            lane_pix = DATA_OUT_VGA[DATA_W-1-8*i -: 8];
      end
   end

   // Issue stage: address register and band-consumed pulse.
   always_ff @(posedge CLK33MHz or posedge RST) begin
      if (RST) begin
         RADDR_VGA <= '0;
         band_done <= 1'b0;
         band_buf  <= 1'b0;
      end else begin
         if (active)
            RADDR_VGA <= raddr_next;
         band_done <= last;
         if (last)
            band_buf <= sel;
      end
   end

   // Side pipeline matching the RAM read latency.
   always_ff @(posedge CLK33MHz or posedge RST) begin
      if (RST) begin
         pipe_act   <= '0;
         pipe_blank <= '0;
         pipe_lane  <= '0;
      end else begin
         pipe_act[0]   <= active;
         pipe_blank[0] <= blank;
         pipe_lane[0]  <= lane;
         for (int unsigned k = 1; k < RD_LAT; k++) begin
            pipe_act[k]   <= pipe_act[k-1];
            pipe_blank[k] <= pipe_blank[k-1];
            pipe_lane[k]  <= pipe_lane[k-1];
         end
      end
   end

   // Output pixel register: zero when inactive, blank pixel on underflow.
   always_ff @(posedge CLK33MHz or posedge RST) begin
      if (RST) begin
         pixel_in    <= '0;
         pixel_valid <= 1'b0;
      end else begin
         pixel_valid <= pipe_act[RD_LAT-1];
         if (!pipe_act[RD_LAT-1])
            pixel_in <= '0;
         else if (pipe_blank[RD_LAT-1])
            pixel_in <= BLANK_PIX;
         else
            pixel_in <= lane_pix;
      end
   end

   // Buffer handshake and sticky underflow; set beats clear in both.
   always_ff @(posedge CLK33MHz or posedge RST) begin
      if (RST) begin
         buf_valid <= '0;
         underflow <= 1'b0;
      end else begin
         buf_valid <= (buf_valid & ~clr_mask) | fill_done;
         if (blank)
            underflow <= 1'b1;
         else if (clr_underflow)
            underflow <= 1'b0;
      end
   end

endmodule
